// File: rtl/mac_pe_pkg.sv
// rtl/mac_pe_pkg.sv - shared constants and pipeline-stage types for the integer MAC PE
package mac_pe_pkg;

  localparam int DEF_DATA_WIDTH = 32;

  // Edges from the sampling edge of a last element to the dout/dvalid update.
  localparam int PE_LATENCY = 3;

  // Control bits that travel down the pipeline with each element.
  typedef struct packed {
    logic valid;
    logic clear;
    logic last;
  } pe_ctrl_t;

  // Full stage record at the default width (control plus data word).
  typedef struct packed {
    logic                      valid;
    logic                      clear;
    logic                      last;
    logic [DEF_DATA_WIDTH-1:0] data;
  } pe_stage_t;

endpackage

// File: rtl/mac_pe_int_if.sv
// rtl/mac_pe_int_if.sv - controller-to-PE bus: local-RAM write port, MAC element stream, result
// master: controller side (drives we/addr/din/valid/ain/clear/last, receives dout/dvalid)
// slave : PE side
interface mac_pe_int_if
  import mac_pe_pkg::*;
#(
  parameter int L_RAM_SIZE = 6,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  we;
  logic [L_RAM_SIZE-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  valid;
  logic [DATA_WIDTH-1:0] ain;
  logic                  clear;
  logic                  last;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dvalid;

  modport master (
    output we, addr, din, valid, ain, clear, last,
    input  dout, dvalid
  );

  modport slave (
    input  we, addr, din, valid, ain, clear, last,
    output dout, dvalid
  );

endinterface

// File: rtl/pe_lram.sv
// rtl/pe_lram.sv - single-address synchronous read-first RAM with write enable
// Ports: clk; we/addr/din write port; rdata = contents of addr before this edge's write.
// Contents are not reset.
module pe_lram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read and write in the same process so a colliding access returns old data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mac_pe_int.sv
// rtl/mac_pe_int.sv - integer multiply-accumulate PE: 3-stage datapath plus dout/dvalid registers
// Ports: aclk; aresetn (synchronous, active-low); bus (slave modport of mac_pe_int_if):
//   we/addr/din load the local RAM, valid/ain/clear/last stream MAC elements,
//   dout/dvalid return each completed dot product with a one-cycle pulse.
module mac_pe_int
  import mac_pe_pkg::*;
#(
  parameter int L_RAM_SIZE = 6,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic         aclk,
  input logic         aresetn,
  mac_pe_int_if.slave bus
);

  pe_ctrl_t              s1_ctrl;
  pe_ctrl_t              s2_ctrl;
  logic                  s3_done;
  logic [DATA_WIDTH-1:0] s1_ain;
  logic [DATA_WIDTH-1:0] s2_prod;
  logic [DATA_WIDTH-1:0] lram_q;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dvalid_q;

  // S1 RAM read: lram_q lines up with s1_ain.
  pe_lram #(
    .ADDR_WIDTH(L_RAM_SIZE),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lram (
    .clk  (aclk),
    .we   (bus.we),
    .addr (bus.addr),
    .din  (bus.din),
    .rdata(lram_q)
  );

  // Data words need no reset; only the valid-qualified control is cleared.
  always_ff @(posedge aclk) begin
    s1_ain  <= bus.ain;
    // Low DATA_WIDTH bits of the product are identical for signed and unsigned operands.
    s2_prod <= s1_ain * lram_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s1_ctrl  <= '0;
      s2_ctrl  <= '0;
      s3_done  <= 1'b0;
      acc      <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      // clear/last are meaningless without valid, so they are masked on entry.
      s1_ctrl.valid <= bus.valid;
      s1_ctrl.clear <= bus.valid & bus.clear;
      s1_ctrl.last  <= bus.valid & bus.last;
      s2_ctrl       <= s1_ctrl;

      // S3: accumulate; bubbles leave acc untouched.
      if (s2_ctrl.valid) begin
        acc <= s2_ctrl.clear ? s2_prod : acc + s2_prod;
      end
      s3_done <= s2_ctrl.valid & s2_ctrl.last;

      // Output registers capture acc once the last element has been folded in.
      dvalid_q <= s3_done;
      if (s3_done) begin
        dout_q <= acc;
      end
    end
  end

  assign bus.dout   = dout_q;
  assign bus.dvalid = dvalid_q;

endmodule
